modn_updown_counter_p: RTL
==========================

Name: modn_updown_counter_p

Overview:
- Parametrised, synchronous, loadable modulo-N up/down counter with programmable step size.
- Next generation of the team's fixed mod-14 counter: width and modulus are generalised.
- Adds count enable, saturate mode, wrap/borrow pulse, terminal flags and load-rejection reporting.
- Used as a timebase and sequence index in control datapaths; can be cascaded through the wrap pulse.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 14, count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH; elaboration error otherwise.
- STEP_W, 2, width of the step input.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- enable  in  1  count enable
- load  in  1  synchronous load request
- data_in  in  WIDTH  load value
- up_down  in  1  1 = count up, 0 = count down
- sat_mode  in  1  1 = saturate at the ends, 0 = wrap modulo MODULUS
- step  in  STEP_W  increment/decrement amount
- count  out  WIDTH  current count, registered
- wrap  out  1  registered 1-cycle pulse on wrap-around or borrow
- sat_hit  out  1  registered 1-cycle pulse when a step was clamped
- at_max  out  1  combinational, count == MODULUS-1
- at_zero  out  1  combinational, count == 0
- load_rej  out  1  registered 1-cycle pulse when a load was rejected

Behaviour:
- Reset (reset=0, asynchronous)
  - count=0, wrap=0, sat_hit=0, load_rej=0 immediately, independent of clock.
  - Deassertion takes effect on the first rising edge with reset=1.
  - Reset mid-operation discards any in-flight load or step.
- Priority per rising edge: load > enable-count > hold.
- wrap, sat_hit and load_rej default to 0 each cycle unless set by the rules below.
- Load (load=1)
  - data_in < MODULUS: count <= data_in.
  - data_in >= MODULUS: count holds and load_rej=1 for one cycle.
  - Either way no counting occurs that cycle, even if enable=1.
- Hold: load=0 and enable=0 -> count holds.
- Counting (load=0, enable=1), with s = step zero-extended:
  - s == 0: count holds, no pulses.
  - s >= MODULUS: count holds, no pulses (illegal step, treated as a no-op).
- Up, wrap mode (sat_mode=0):
  - sum = count + s, computed at WIDTH+1 bits.
  - sum >= MODULUS: count <= sum - MODULUS, wrap=1. Otherwise count <= sum.
- Up, saturate mode (sat_mode=1):
  - sum >= MODULUS: count <= MODULUS-1, sat_hit=1. Otherwise count <= sum.
  - sat_hit pulses even if count was already MODULUS-1.
- Down, wrap mode:
  - count >= s: count <= count - s.
  - Otherwise count <= count + MODULUS - s, wrap=1.
- Down, saturate mode:
  - count < s: count <= 0, sat_hit=1. Otherwise count <= count - s.
- All intermediate arithmetic is WIDTH+1 bits; no overflow is permitted at MODULUS = 2**WIDTH.
- count never leaves 0..MODULUS-1.
- Latency: count and pulses update one clock after the sampled inputs. at_max and at_zero follow count with no added delay.
- up_down, sat_mode and step are sampled every edge; changing them between cycles is legal with no settling.

Optional Feature:
- Macro: MODN_CNT_STICKY_ERR_EN
- Defined:
  - Adds output err_sticky (1 bit).
  - Set on any rejected load or illegal step (s >= MODULUS with enable=1, load=0).
  - Cleared only by reset, or by a legal load (data_in < MODULUS), which clears it on that edge.
  - A rejected load and a clear cannot coincide.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Defaults (MODULUS=14), up, step=1, enable=1, wrap mode, start 12 -> sequence 13, 0 (wrap=1 on the 13->0 edge only), 1.
- Down, step=1, from 0 -> 13 with wrap=1; next cycle 12 with wrap=0.
- step=3, up, from 12 -> 1 with wrap=1. Then sat_mode=1 from 12 -> 13 with sat_hit=1; a further step stays 13 with sat_hit=1.
- load=1, data_in=14 while enable=1 and count=5 -> count stays 5, load_rej=1 for one cycle. Then data_in=9 -> count=9, load_rej=0, err_sticky cleared when the macro is defined.
- Counting at 7, reset pulled low between edges -> count=0 before the next edge; count stays 0 while reset=0 and resumes on the first edge after release.
- MODULUS=16, WIDTH=4, step=3, up, from 15 -> 2 with wrap=1. Down from 1 -> 14 with wrap=1; no X or overflow.

Source files
------------

// File: rtl/modn_updown_counter_p.sv
// modn_updown_counter_p: loadable modulo-MODULUS up/down counter with
// programmable step, wrap or saturate mode, registered wrap/borrow, clamp
// and load-rejection pulses, and combinational terminal flags.
// Optional sticky error output: define MODN_CNT_STICKY_ERR_EN.
module modn_updown_counter_p #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 14,
  parameter int STEP_W  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              up_down,
  input  logic              sat_mode,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  count,
  output logic              wrap,
  output logic              sat_hit,
  output logic              at_max,
  output logic              at_zero,
  output logic              load_rej
`ifdef MODN_CNT_STICKY_ERR_EN
  ,
  output logic              err_sticky
`endif
);

  // Wide enough to hold both the step input and the WIDTH+1 datapath.
  localparam int EXT_W = (STEP_W > WIDTH + 1) ? STEP_W : WIDTH + 1;
  localparam logic [WIDTH:0]   L_MOD = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MODULUS - 1);

  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("modn_updown_counter_p: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_sat_hit;
  logic             r_load_rej;

  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;
  logic             w_sat_nxt;
  logic             w_rej_nxt;

  logic [EXT_W-1:0] w_step_wide;
  logic             w_step_illegal;
  logic [WIDTH:0]   w_s;
  logic [WIDTH:0]   w_cnt_ext;
  logic [WIDTH:0]   w_sum;
  logic             w_data_ok;

  // Step legality is judged at full step width so large steps are never
  // truncated into an apparently legal value.
  assign w_step_wide    = EXT_W'(step);
  assign w_step_illegal = (w_step_wide >= EXT_W'(MODULUS));
  assign w_s            = w_step_wide[WIDTH:0];
  assign w_cnt_ext      = {1'b0, r_count};
  assign w_sum          = w_cnt_ext + w_s;
  assign w_data_ok      = ({1'b0, data_in} < L_MOD);

  // Next count and pulse decode: load beats counting beats hold.
  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    w_sat_nxt   = 1'b0;
    w_rej_nxt   = 1'b0;
    if (load) begin
      if (w_data_ok) begin
        w_count_nxt = data_in;
      end else begin
        w_rej_nxt = 1'b1;
      end
    end else if (enable && (w_s != '0) && !w_step_illegal) begin
      if (up_down) begin
        if (w_sum >= L_MOD) begin
          if (sat_mode) begin
            w_count_nxt = L_MAX;
            w_sat_nxt   = 1'b1;
          end else begin
            w_count_nxt = WIDTH'(w_sum - L_MOD);
            w_wrap_nxt  = 1'b1;
          end
        end else begin
          w_count_nxt = WIDTH'(w_sum);
        end
      end else begin
        if (w_cnt_ext >= w_s) begin
          w_count_nxt = WIDTH'(w_cnt_ext - w_s);
        end else if (sat_mode) begin
          w_count_nxt = '0;
          w_sat_nxt   = 1'b1;
        end else begin
          // count + MODULUS - s stays below 2**(WIDTH+1) even at full modulus.
          w_count_nxt = WIDTH'(w_cnt_ext + L_MOD - w_s);
          w_wrap_nxt  = 1'b1;
        end
      end
    end
  end

  // Count and one-cycle pulse registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_sat_hit  <= 1'b0;
      r_load_rej <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_wrap     <= w_wrap_nxt;
      r_sat_hit  <= w_sat_nxt;
      r_load_rej <= w_rej_nxt;
    end
  end

  assign count    = r_count;
  assign wrap     = r_wrap;
  assign sat_hit  = r_sat_hit;
  assign load_rej = r_load_rej;
  assign at_max   = (r_count == L_MAX);
  assign at_zero  = (r_count == '0);

`ifdef MODN_CNT_STICKY_ERR_EN
  logic r_err;
  logic w_err_set;
  logic w_err_clr;

  assign w_err_clr = load && w_data_ok;
  assign w_err_set = load ? !w_data_ok : (enable && w_step_illegal);

  // Sticky error: set by rejected loads or illegal steps, cleared by a legal load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_err_clr) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign err_sticky = r_err;
`endif

endmodule
